// File: rtl/imem_loader_if.sv
// imem_loader_if: word stream in, byte write bus out
interface imem_loader_if #(parameter int ADDR_WIDTH = 24);
    logic                  in_valid;
    logic                  in_ready;
    logic [23:0]           in_data;
    logic                  in_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    modport master (output in_valid, in_data, in_last, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_valid, in_data, in_last, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writes 24-bit words into byte-addressed memory as 3 big-endian bytes
module imem_loader #(
    parameter int ADDR_WIDTH = 24,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    imem_loader_if.slave          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] word_count
);
    typedef enum logic [2:0] {IDLE, ARMED, WR0, WR1, WR2, FIN} state_t;
    localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [23:0]           data_q;
    logic                  last_q;
    logic                  fits;
    // one extra bit so a pointer near the top of the address space cannot wrap into range
    assign fits         = ({1'b0, wr_ptr} + (ADDR_WIDTH+1)'(2)) <= LAST_BYTE;
    assign bus.in_ready = state == ARMED;
    assign bus.mem_we   = state == WR0 || state == WR1 || state == WR2;
    assign busy         = state != IDLE;
    assign done         = state == FIN;
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ARMED : IDLE;
            ARMED:   state_nxt = !bus.in_valid ? ARMED : fits ? WR0 : FIN;
            WR0:     state_nxt = WR1;
            WR1:     state_nxt = WR2;
            WR2:     state_nxt = last_q ? FIN : ARMED;
            default: state_nxt = IDLE;
        endcase
    end
    // address/data are loaded one edge ahead so the bus is registered when mem_we rises
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            word_count    <= '0;
            error         <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wr_ptr     <= base_addr;
                    word_count <= '0;
                    error      <= 1'b0;
                end
                ARMED: if (bus.in_valid) begin
                    data_q <= bus.in_data;
                    last_q <= bus.in_last;
                    if (fits) begin
                        bus.mem_addr  <= wr_ptr;
                        bus.mem_wdata <= bus.in_data[23:16];
                    end else
                        error <= 1'b1;
                end
                WR0: begin
                    bus.mem_addr  <= wr_ptr + ADDR_WIDTH'(1);
                    bus.mem_wdata <= data_q[15:8];
                end
                WR1: begin
                    bus.mem_addr  <= wr_ptr + ADDR_WIDTH'(2);
                    bus.mem_wdata <= data_q[7:0];
                end
                WR2: begin
                    wr_ptr     <= wr_ptr + ADDR_WIDTH'(3);
                    word_count <= word_count + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard of expected byte writes, checked as the DUT issues them
module tb_imem_loader;
    localparam int AW = 24;
    localparam int DEPTH = 1024;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, error;
    logic [AW-1:0] word_count;
    int            checks = 0;
    int            errors = 0;
    int            ptr = 0;
    int            wc = 0;
    logic [AW+7:0] exp_q[$];
    imem_loader_if #(.ADDR_WIDTH(AW)) bus();
    imem_loader #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .bus(bus),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        logic [AW+7:0] e;
        @(negedge clk);
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 'x;
            check("wr_byte", {bus.mem_addr, bus.mem_wdata}, e);
            check("wr_ready", bus.in_ready, 0);
            check("wr_range", bus.mem_addr < DEPTH, 1);
        end
    endtask
    task automatic begin_session(input int base);
        start = 1'b1;
        base_addr = AW'(base);
        tick();
        start = 1'b0;
        ptr = base;
        wc = 0;
        check("armed", bus.in_ready, 1);
        check("clr_error", error, 0);
        check("clr_count", word_count, 0);
    endtask
    task automatic send_word(input logic [23:0] d, input logic last);
        bit fits;
        int n;
        fits = ptr + 2 <= DEPTH - 1;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = last;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("accept_wait", n < 20, 1);
        if (fits) begin
            exp_q.push_back({AW'(ptr), d[23:16]});
            exp_q.push_back({AW'(ptr + 1), d[15:8]});
            exp_q.push_back({AW'(ptr + 2), d[7:0]});
        end
        tick();
        bus.in_valid = 1'b0;
        if (fits) begin
            for (int i = 0; i < 3; i++) begin
                check("wr_lat", bus.mem_we, 1);
                tick();
            end
            ptr += 3;
            wc++;
        end
        if (last || !fits) begin
            check("done", done, 1);
            check("fin_busy", busy, 1);
            check("fin_ready", bus.in_ready, 0);
            tick();
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
            check("word_count", word_count, wc);
            check("error", error, !fits);
            check("sb_empty", exp_q.size(), 0);
        end else
            check("rearm", bus.in_ready, 1);
    endtask
    initial begin
        bus.in_valid = 1'b1;
        bus.in_data = 24'hFFFFFF;
        bus.in_last = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        check("rst_ready", bus.in_ready, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", word_count, 0);
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);
        begin_session(0);
        send_word(24'h102BFF, 1'b1);
        begin_session(3);
        send_word(24'h1E2801, 1'b0);
        check("mid_count", word_count, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ready", bus.in_ready, 1);
            check("stall_we", bus.mem_we, 0);
        end
        send_word(24'hAABBCC, 1'b1);
        begin_session(1020);
        send_word(24'h445566, 1'b0);
        send_word(24'h778899, 1'b1);
        begin_session(0);
        bus.in_valid = 1'b1;
        bus.in_data = 24'h123456;
        bus.in_last = 1'b1;
        exp_q.push_back({AW'(0), 8'h12});
        exp_q.push_back({AW'(1), 8'h34});
        tick();
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid_we", bus.mem_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sb", exp_q.size(), 0);
        reset = 1'b1;
        tick();
        begin_session(0);
        send_word(24'hC0FFEE, 1'b1);
        begin_session(30);
        send_word(24'h010203, 1'b0);
        start = 1'b1;
        base_addr = AW'(500);
        tick();
        start = 1'b0;
        check("start_ignored_busy", busy, 1);
        check("start_ignored_ready", bus.in_ready, 1);
        send_word(24'h040506, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
